mux_arb4: RTL and testbench
===========================

# mux_arb4

Four-requester round-robin arbiter that owns the select of a 4:1 data multiplexer and shares its single output between four producers. It tracks ownership, drives the mux select, and presents the selected word on a valid/ready output port. Downstream sees one stream, and each producer gets a one-hot accept pulse for every beat taken from it.

## Interface
Parameters:
- `WIDTH`, 8: data word width per requester.
- `MAX_BURST`, 4: maximum consecutive beats per grant. Legal range is 1 to 255. Used only when `MUX_ARB_BURST_EN` is defined.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 4: request level, one bit per requester.
- `data_inputs` in 4*WIDTH: requester i word at bits [i*WIDTH +: WIDTH].
- `select` out 2: registered mux select, the encoded index of the current owner.
- `gnt` out 4: one-hot owner indication; all zero when idle.
- `accept` out 4: one-hot beat pulse, equal to `gnt` & {4{`out_valid` & `out_ready`}}.
- `out_data` out WIDTH: `data_inputs[select]` when `out_valid` is high, otherwise 0.
- `out_valid` out 1: equal to (state == GRANT) & `req[select]`.
- `out_ready` in 1: downstream accepts a beat when high together with `out_valid`.
- `busy` out 1: high while state == GRANT.

## Operation
State machine:
- IDLE:
  - If `req` is nonzero, pick the winner.
  - Load `select` and `gnt` with the winner.
  - Go to GRANT.
- GRANT, beat (`out_valid` & `out_ready`):
  - Pulse `accept[select]`.
  - Set the pointer to `select`.
  - Re-arbitrate in the same cycle using the current `req`, which includes the owner's bit.
  - If there is a winner, stay in GRANT with the new owner. Otherwise go to IDLE.
- GRANT, withdrawal (`req[select]` low):
  - No beat and no accept.
  - Set the pointer to `select`.
  - Re-arbitrate exactly as for a beat.
- GRANT, stall (`req[select]` high and `out_ready` low): hold every output and the pointer unchanged.

Winner selection:
- Choose the first set bit of `req`, scanning from (pointer+1) mod 4 upward and wrapping 3→0.
- The pointer is 2 bits and resets to 3, so requester 0 wins first after reset.

Protocol rule: a requester keeps `data_inputs` slot i stable from the cycle `gnt[i]` rises until its `accept[i]` pulse.

Simultaneous events:
- When a beat coincides with new requests, the new requests take part in the same-cycle re-arbitration.
- The owner re-requesting is treated as an ordinary contender at lowest priority, because the pointer now equals the owner.

Reset values:
- `select`=0, `gnt`=0, `accept`=0, `out_valid`=0, `out_data`=0, `busy`=0.
- Pointer=3, beat counter=0, state=IDLE.

Reset mid-operation: outputs clear immediately and asynchronously. An in-flight beat is lost and produces no accept.

## Timing
- A request in IDLE produces `out_valid` one cycle later. There is no combinational path from `req` to `gnt` in IDLE.
- While requests remain pending, beats flow back-to-back at one per cycle with no bubble on an owner change.
- `out_data` is combinational from `data_inputs` and `select`. `select` and `gnt` are registered.
- A stall of any length holds `select`, `gnt` and `out_data` stable.

## Configuration
`MUX_ARB_BURST_EN`:
- Defined:
  - An 8-bit beat counter allows the owner to keep the grant for consecutive beats.
  - On a beat where `req[select]` is high and counter < `MAX_BURST`-1, the owner is retained, the counter increments, and the pointer is left unchanged.
  - Otherwise the normal rotation applies and the counter clears.
  - Withdrawal clears the counter.
- Undefined:
  - No counter is built and `MAX_BURST` is ignored.
  - Ownership rotates after every beat, equivalent to `MAX_BURST`=1.

## Test plan
- After reset, `req`=4'b1111 and `out_ready`=1 held for 8 cycles → `select` sequence 0,1,2,3,0,1,2,3 with one `accept` per cycle and no bubbles. With the macro defined and `MAX_BURST`=2 → sequence 0,0,1,1,2,2,3,3.
- Only `req`[2]=1, `data_inputs` slot 2=8'hA5, `out_ready`=0 for 3 cycles then 1 → `out_valid` rises one cycle after `req`. `out_data`=8'hA5 is held stable through the stall, followed by a single `accept`=4'b0100.
- Owner 1 active with `req`=4'b1010 and `out_ready`=1 → the next owner is 3, not 1. Then with only `req`[1] high → the owner is 1 again.
- `req`[0] drops while `gnt`=4'b0001, `req`[3]=1, `out_ready`=0 → `out_valid` goes low with no accept. The following cycle `gnt`=4'b1000.
- `rst` asserted mid-stall with `out_valid`=1 → all outputs clear before the next clock edge. After release with `req`=4'b1111, the first `select` is 0.
- `req` goes to 0 after a beat → IDLE with `busy`=0 and `gnt`=0. A later `req`=4'b0100 → `gnt`=4'b0100 after one cycle.

Source files
------------

// File: rtl/mux_arb4_if.sv
// Bundle for mux_arb4: requester side (req, data_inputs), the arbiter's grant/select view,
// and the merged valid/ready output stream.
// master: the arbiter. slave: the environment that drives requests and consumes the stream.
interface mux_arb4_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [3:0]         req;
  logic [4*WIDTH-1:0] data_inputs;
  logic [1:0]         select;
  logic [3:0]         gnt;
  logic [3:0]         accept;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  modport master (
    input  req, data_inputs, out_ready,
    output select, gnt, accept, out_data, out_valid, busy
  );

  modport slave (
    output req, data_inputs, out_ready,
    input  select, gnt, accept, out_data, out_valid, busy
  );
endinterface

// File: rtl/mux_arb4.sv
// mux_arb4: four-requester round-robin arbiter driving the select of a 4:1 data mux and
// presenting the chosen word on a single valid/ready stream.
// Optional feature macro: MUX_ARB_BURST_EN (owner may hold the grant for up to MAX_BURST beats).
module mux_arb4 #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  mux_arb4_if.master  bus
);

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("mux_arb4: MAX_BURST must be in 1..255");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] select_q, select_d;
  logic [3:0] gnt_q, gnt_d;
`ifdef MUX_ARB_BURST_EN
  logic [7:0] burst_cnt_q, burst_cnt_d;
`endif

  logic       owner_req;
  logic       out_valid;
  logic       beat;
  logic [1:0] arb_ptr;
  logic [2:0] pick;   // {found, index}

  // First set bit of r scanning from p+1 upward with wrap; nearest candidate wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int i = 4; i > 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Output stream and handshake decode.
  always_comb begin
    owner_req = bus.req[select_q];
    out_valid = (state_q == StGrant) && owner_req;
    beat      = out_valid && bus.out_ready;
  end

  // In GRANT the pointer for re-arbitration is the current owner, so it ranks last.
  always_comb begin
    arb_ptr = (state_q == StGrant) ? select_q : ptr_q;
    pick    = rr_pick(bus.req, arb_ptr);
  end

  // Next-state logic: arbitration, rotation and optional burst retention.
  always_comb begin
    logic rotate;
    state_d  = state_q;
    ptr_d    = ptr_q;
    select_d = select_q;
    gnt_d    = gnt_q;
    rotate   = 1'b0;
`ifdef MUX_ARB_BURST_EN
    burst_cnt_d = burst_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (pick[2]) begin
          state_d  = StGrant;
          select_d = pick[1:0];
          gnt_d    = 4'b0001 << pick[1:0];
        end
      end
      StGrant: begin
        if (!owner_req) begin
          rotate = 1'b1;
        end else if (beat) begin
`ifdef MUX_ARB_BURST_EN
          if (32'(burst_cnt_q) < MAX_BURST - 1) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end else begin
            rotate = 1'b1;
          end
`else
          rotate = 1'b1;
`endif
        end
        // Otherwise a stall: everything holds.
      end
      default: state_d = StIdle;
    endcase

    if (rotate) begin
      ptr_d = select_q;
`ifdef MUX_ARB_BURST_EN
      burst_cnt_d = 8'd0;
`endif
      if (pick[2]) begin
        state_d  = StGrant;
        select_d = pick[1:0];
        gnt_d    = 4'b0001 << pick[1:0];
      end else begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
      end
    end
  end

  // State registers; pointer resets to 3 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= 2'd3;
      select_q <= 2'd0;
      gnt_q    <= 4'b0000;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      select_q <= select_d;
      gnt_q    <= gnt_d;
    end
  end

`ifdef MUX_ARB_BURST_EN
  // Consecutive-beat counter for the current owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt_q <= 8'd0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`endif

  // Drive the bundle outputs.
  always_comb begin
    bus.select    = select_q;
    bus.gnt       = gnt_q;
    bus.busy      = (state_q == StGrant);
    bus.out_valid = out_valid;
    bus.accept    = gnt_q & {4{beat}};
    bus.out_data  = out_valid ? bus.data_inputs[select_q*WIDTH +: WIDTH] : '0;
  end

endmodule

// File: tb/tb_mux_arb4.sv
// Directed bench for mux_arb4 with a scoreboard of expected beats (owner index + word).
module tb_mux_arb4;
  localparam int unsigned Width    = 8;
  localparam int unsigned MaxBurst = 2;
`ifdef MUX_ARB_BURST_EN
  localparam int unsigned BurstLen = MaxBurst;
`else
  localparam int unsigned BurstLen = 1;
`endif

  typedef struct packed {
    logic [1:0]       sel;
    logic [Width-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   fails   = 0;
  beat_t exp_q[$];
  logic [Width-1:0] slot [4];

  mux_arb4_if #(.WIDTH(Width)) bus ();

  mux_arb4 #(.WIDTH(Width), .MAX_BURST(MaxBurst)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] sel);
    beat_t b;
    b.sel  = sel;
    b.data = slot[sel];
    exp_q.push_back(b);
  endtask

  // A beat must be on offer now: compare it against the oldest expectation.
  task automatic sb_beat(input string tag);
    beat_t b;
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    if (exp_q.size() == 0) begin
      vectors++;
      fails++;
      $error("FAIL %s_sb observed=beat expected=empty_scoreboard", tag);
    end else begin
      b = exp_q.pop_front();
      chk({tag, "_sel"}, 32'(bus.select), 32'(b.sel));
      chk({tag, "_data"}, 32'(bus.out_data), 32'(b.data));
      chk({tag, "_accept"}, 32'(bus.accept), 32'(4'b0001 << b.sel));
    end
  endtask

  initial begin
    slot[0] = 8'h5A;
    slot[1] = 8'h3C;
    slot[2] = 8'hA5;
    slot[3] = 8'hC3;
    bus.data_inputs = {slot[3], slot[2], slot[1], slot[0]};
    bus.req         = 4'b0000;
    bus.out_ready   = 1'b0;
    rst             = 1'b1;
    #12;

    // Reset values
    chk("rst_select", 32'(bus.select), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_accept", 32'(bus.accept), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    cyc();
    cyc();

    // Round robin with all requesting, no bubbles
    rst = 1'b0;
    bus.req = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    chk("idle_no_comb_gnt", 32'(bus.gnt), 32'd0);
    chk("idle_no_comb_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 8; i++) push(2'((i / BurstLen) % 4));
    cyc();
    for (int i = 0; i < 8; i++) begin
      sb_beat("rr");
      cyc();
    end
    bus.req = 4'b0000;
    #1;
    chk("drop_valid", 32'(bus.out_valid), 32'd0);
    chk("drop_accept", 32'(bus.accept), 32'd0);
    cyc();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_gnt", 32'(bus.gnt), 32'd0);

    // Single requester 2 with a 3-cycle stall
    bus.req = 4'b0100;
    bus.out_ready = 1'b0;
    #1;
    chk("lat_pre_valid", 32'(bus.out_valid), 32'd0);
    cyc();
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_gnt", 32'(bus.gnt), 32'b0100);
    chk("stall0_data", 32'(bus.out_data), 32'hA5);
    chk("stall0_accept", 32'(bus.accept), 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("stall_data", 32'(bus.out_data), 32'hA5);
      chk("stall_select", 32'(bus.select), 32'd2);
      chk("stall_accept", 32'(bus.accept), 32'd0);
    end
    cyc();
    bus.out_ready = 1'b1;
    push(2'd2);
    #1;
    sb_beat("stall_release");
    cyc();
    bus.req = 4'b0000;
    #1;
    chk("wd_accept", 32'(bus.accept), 32'd0);
    cyc();
    chk("idle2_busy", 32'(bus.busy), 32'd0);
    chk("idle2_gnt", 32'(bus.gnt), 32'd0);

    // Owner 1 with req 1010: next owner is 3
    bus.req = 4'b0010;
    bus.out_ready = 1'b0;
    cyc();
    chk("own1_gnt", 32'(bus.gnt), 32'b0010);
    bus.req = 4'b1010;
    bus.out_ready = 1'b1;
    for (int i = 0; i < int'(BurstLen); i++) push(2'd1);
    #1;
    for (int i = 0; i < int'(BurstLen); i++) begin
      sb_beat("own1");
      cyc();
    end
    bus.req = 4'b0010;
    #1;
    chk("next3_select", 32'(bus.select), 32'd3);
    chk("next3_gnt", 32'(bus.gnt), 32'b1000);
    chk("next3_wd_valid", 32'(bus.out_valid), 32'd0);
    chk("next3_wd_accept", 32'(bus.accept), 32'd0);
    cyc();
    chk("back1_gnt", 32'(bus.gnt), 32'b0010);
    chk("back1_select", 32'(bus.select), 32'd1);

    // Withdrawal by owner 0 while requester 3 waits
    bus.out_ready = 1'b0;
    bus.req = 4'b0001;
    #1;
    chk("to0_valid", 32'(bus.out_valid), 32'd0);
    cyc();
    chk("own0_gnt", 32'(bus.gnt), 32'b0001);
    bus.req = 4'b1001;
    #1;
    chk("own0_stall_valid", 32'(bus.out_valid), 32'd1);
    chk("own0_stall_accept", 32'(bus.accept), 32'd0);
    cyc();
    chk("own0_hold_gnt", 32'(bus.gnt), 32'b0001);
    bus.req = 4'b1000;
    #1;
    chk("wd0_valid", 32'(bus.out_valid), 32'd0);
    chk("wd0_accept", 32'(bus.accept), 32'd0);
    cyc();
    chk("wd0_next_gnt", 32'(bus.gnt), 32'b1000);
    chk("wd0_next_select", 32'(bus.select), 32'd3);

    // Asynchronous reset mid-stall
    #1;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_select", 32'(bus.select), 32'd0);
    chk("arst_gnt", 32'(bus.gnt), 32'd0);
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_data", 32'(bus.out_data), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_accept", 32'(bus.accept), 32'd0);
    cyc();
    rst = 1'b0;
    bus.req = 4'b1111;
    bus.out_ready = 1'b1;
    push(2'd0);
    cyc();
    sb_beat("post_rst");
    chk("post_rst_gnt", 32'(bus.gnt), 32'b0001);
    bus.req = 4'b0000;
    cyc();
    cyc();
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
